// File: rtl/pcie_tx_credit_model.sv
// pcie_tx_credit_model
// Cycle-level model of the PCIe hard IP transmit flow-control credit pools.
// Consumes the core's per-segment credit strobes and drives back the six
// available-credit counts, a sticky error flag and a periodic tx_st_ready.
//
// Optional feature macro: PCIE_TX_CREDIT_RETURN_EN
//   defined     - consumed credits come back after RETURN_LATENCY cycles
//                 (models link-partner UpdateFC).
//   not defined - no return path; pools only drain (stalled link partner).
`timescale 1ns/1ps

module pcie_tx_credit_model #(
    parameter int          SEG_COUNT      = 2,
    parameter logic [7:0]  INIT_PH        = 8'd32,
    parameter logic [11:0] INIT_PD        = 12'd512,
    parameter logic [7:0]  INIT_NPH       = 8'd32,
    parameter logic [11:0] INIT_NPD       = 12'd64,
    parameter logic [7:0]  INIT_CPLH      = 8'd32,
    parameter logic [11:0] INIT_CPLD      = 12'd512,
    parameter int          RETURN_LATENCY = 8,
    parameter int          READY_PERIOD   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEG_COUNT-1:0]   tx_hdr_cdts_consumed,
    input  logic [SEG_COUNT-1:0]   tx_data_cdts_consumed,
    input  logic [2*SEG_COUNT-1:0] tx_cdts_type,
    input  logic [SEG_COUNT-1:0]   tx_cdts_data_value,
    output logic [7:0]             tx_ph_cdts,
    output logic [7:0]             tx_nph_cdts,
    output logic [7:0]             tx_cplh_cdts,
    output logic [11:0]            tx_pd_cdts,
    output logic [11:0]            tx_npd_cdts,
    output logic [11:0]            tx_cpld_cdts,
    output logic                   tx_st_ready,
    output logic                   credit_err
);

    localparam int HW = $clog2(SEG_COUNT + 1);
    localparam int DW = $clog2(2 * SEG_COUNT + 1);

    // Per-type credit amounts moved in one cycle (consumed or returned).
    typedef struct packed {
        logic [HW-1:0] ph;
        logic [HW-1:0] nph;
        logic [HW-1:0] cplh;
        logic [DW-1:0] pd;
        logic [DW-1:0] npd;
        logic [DW-1:0] cpld;
    } sums_t;

    if (RETURN_LATENCY < 1 || RETURN_LATENCY > 64) begin : g_bad_latency
        $error("RETURN_LATENCY must be in 1..64");
    end

    sums_t       cons;
    sums_t       ret;
    logic        rsvd_hit;
    logic [1:0]  seg_type;
    logic [DW-1:0] data_amt;

    // Sum this cycle's consumption per type over all segments; flag reserved types.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        cons     = '0;
        rsvd_hit = 1'b0;
        seg_type = '0;
        data_amt = '0;
        for (int s = 0; s < SEG_COUNT; s++) begin
            seg_type = tx_cdts_type[2*s +: 2];
            data_amt = tx_cdts_data_value[s] ? DW'(2) : DW'(1);
            case (seg_type)
                2'b00: begin
                    if (tx_hdr_cdts_consumed[s])  cons.ph = cons.ph + HW'(1);
                    if (tx_data_cdts_consumed[s]) cons.pd = cons.pd + data_amt;
                end
                2'b01: begin
                    if (tx_hdr_cdts_consumed[s])  cons.nph = cons.nph + HW'(1);
                    if (tx_data_cdts_consumed[s]) cons.npd = cons.npd + data_amt;
                end
                2'b10: begin
                    if (tx_hdr_cdts_consumed[s])  cons.cplh = cons.cplh + HW'(1);
                    if (tx_data_cdts_consumed[s]) cons.cpld = cons.cpld + data_amt;
                end
                default: begin
                    if (tx_hdr_cdts_consumed[s] || tx_data_cdts_consumed[s])
                        rsvd_hit = 1'b1;
                end
            endcase
        end
    end

`ifdef PCIE_TX_CREDIT_RETURN_EN
    sums_t ret_pipe [RETURN_LATENCY];

    // Delay line carrying each cycle's consumption back as returned credits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this storage is reset on purpose: a reset must discard
            // every in-flight return, otherwise stale credits would land on
            // freshly restored pools and overflow them.
            for (int i = 0; i < RETURN_LATENCY; i++) ret_pipe[i] <= '0;
        end else begin
            ret_pipe[0] <= cons;
            for (int i = 1; i < RETURN_LATENCY; i++) ret_pipe[i] <= ret_pipe[i-1];
        end
    end

    assign ret = ret_pipe[RETURN_LATENCY-1];
`else
    assign ret = '0;
`endif

    // Header pool update: {err, value}. Signed arithmetic with spare headroom
    // so the pre-clamp result can go below zero or above the limit.
    function automatic logic [8:0] upd_hdr(input logic [7:0] cur,
                                           input logic [HW-1:0] sub,
                                           input logic [HW-1:0] add,
                                           input logic [7:0] lim);
        logic signed [9:0] t;
        t = $signed({2'b00, cur}) - $signed(10'(sub)) + $signed(10'(add));
        if (t < 0)                          return {1'b1, 8'd0};
        else if (t > $signed({2'b00, lim})) return {1'b1, lim};
        else                                return {1'b0, t[7:0]};
    endfunction

    // Data pool update: {err, value}.
    function automatic logic [12:0] upd_data(input logic [11:0] cur,
                                             input logic [DW-1:0] sub,
                                             input logic [DW-1:0] add,
                                             input logic [11:0] lim);
        logic signed [13:0] t;
        t = $signed({2'b00, cur}) - $signed(14'(sub)) + $signed(14'(add));
        if (t < 0)                          return {1'b1, 12'd0};
        else if (t > $signed({2'b00, lim})) return {1'b1, lim};
        else                                return {1'b0, t[11:0]};
    endfunction

    logic [7:0]  ph_n, nph_n, cplh_n;
    logic [11:0] pd_n, npd_n, cpld_n;
    logic        e_ph, e_nph, e_cplh, e_pd, e_npd, e_cpld;
    logic        err_n;

    // Net consumption and returns for every pool in one update.
    always_comb begin
        {e_ph,   ph_n}   = upd_hdr(tx_ph_cdts,     cons.ph,   ret.ph,   INIT_PH);
        {e_nph,  nph_n}  = upd_hdr(tx_nph_cdts,    cons.nph,  ret.nph,  INIT_NPH);
        {e_cplh, cplh_n} = upd_hdr(tx_cplh_cdts,   cons.cplh, ret.cplh, INIT_CPLH);
        {e_pd,   pd_n}   = upd_data(tx_pd_cdts,    cons.pd,   ret.pd,   INIT_PD);
        {e_npd,  npd_n}  = upd_data(tx_npd_cdts,   cons.npd,  ret.npd,  INIT_NPD);
        {e_cpld, cpld_n} = upd_data(tx_cpld_cdts,  cons.cpld, ret.cpld, INIT_CPLD);
        err_n = credit_err | rsvd_hit | e_ph | e_nph | e_cplh | e_pd | e_npd | e_cpld;
    end

    // Credit pools and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ph_cdts   <= INIT_PH;
            tx_nph_cdts  <= INIT_NPH;
            tx_cplh_cdts <= INIT_CPLH;
            tx_pd_cdts   <= INIT_PD;
            tx_npd_cdts  <= INIT_NPD;
            tx_cpld_cdts <= INIT_CPLD;
            credit_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            tx_ph_cdts   <= ph_n;
            tx_nph_cdts  <= nph_n;
            tx_cplh_cdts <= cplh_n;
            tx_pd_cdts   <= pd_n;
            tx_npd_cdts  <= npd_n;
            tx_cpld_cdts <= cpld_n;
            credit_err   <= err_n;
        end
    end

    localparam int RW = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;
    localparam logic [RW-1:0] RDY_LAST = RW'((READY_PERIOD > 1) ? READY_PERIOD - 1 : 0);

    logic [RW-1:0] rdy_cnt, rdy_cnt_n;
    logic          ready_n;

    // Free-running backpressure counter; ready drops on its last count.
    always_comb begin
        rdy_cnt_n = '0;
        ready_n   = 1'b1;
        if (READY_PERIOD > 1) begin
            rdy_cnt_n = (rdy_cnt == RDY_LAST) ? '0 : rdy_cnt + RW'(1);
            ready_n   = (rdy_cnt_n != RDY_LAST);
        end
    end

    // Ready counter and registered tx_st_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_cnt     <= '0;
            tx_st_ready <= 1'b1;
        end else begin
            rdy_cnt     <= rdy_cnt_n;
            tx_st_ready <= ready_n;
        end
    end

endmodule

// File: tb/tb_pcie_tx_credit_model.sv
// Self-checking bench for pcie_tx_credit_model (READY_PERIOD=4, other
// parameters default). Expectations follow PCIE_TX_CREDIT_RETURN_EN.
`timescale 1ns/1ps

module tb_pcie_tx_credit_model;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hdr, data, val;
    logic [3:0]  typ;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;
    logic        ready, err;

    int checks = 0;
    int errors = 0;

    pcie_tx_credit_model #(.READY_PERIOD(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .tx_hdr_cdts_consumed  (hdr),
        .tx_data_cdts_consumed (data),
        .tx_cdts_type          (typ),
        .tx_cdts_data_value    (val),
        .tx_ph_cdts            (ph),
        .tx_nph_cdts           (nph),
        .tx_cplh_cdts          (cplh),
        .tx_pd_cdts            (pd),
        .tx_npd_cdts           (npd),
        .tx_cpld_cdts          (cpld),
        .tx_st_ready           (ready),
        .credit_err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] hdr, data;
        logic [3:0] typ;
        logic [1:0] val;
        int ph, pd, nph, npd, cplh, cpld, err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] h, input logic [1:0] d,
                         input logic [3:0] t, input logic [1:0] v);
        hdr = h; data = d; typ = t; val = v;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 4'b0000, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_all(input string p, input int e_ph, input int e_pd,
                             input int e_nph, input int e_npd, input int e_cplh,
                             input int e_cpld, input int e_err);
        check({p, "_ph"},   int'(ph),   e_ph);
        check({p, "_pd"},   int'(pd),   e_pd);
        check({p, "_nph"},  int'(nph),  e_nph);
        check({p, "_npd"},  int'(npd),  e_npd);
        check({p, "_cplh"}, int'(cplh), e_cplh);
        check({p, "_cpld"}, int'(cpld), e_cpld);
        check({p, "_err"},  int'(err),  e_err);
    endtask

    initial begin
        //          hdr    data   typ      val    ph  pd   nph npd cplh cpld err
        vecs[0] = '{2'b01, 2'b01, 4'b0000, 2'b01, 31, 510, 32, 64, 32, 512, 0};
        vecs[1] = '{2'b11, 2'b11, 4'b0101, 2'b10, 32, 512, 30, 61, 32, 512, 0};
        vecs[2] = '{2'b10, 2'b01, 4'b0010, 2'b00, 31, 512, 32, 64, 32, 511, 0};
        vecs[3] = '{2'b11, 2'b01, 4'b0011, 2'b00, 31, 512, 32, 64, 32, 512, 1};
        vecs[4] = '{2'b11, 2'b11, 4'b1111, 2'b11, 32, 512, 32, 64, 32, 512, 1};
        vecs[5] = '{2'b00, 2'b00, 4'b1111, 2'b11, 32, 512, 32, 64, 32, 512, 0};
        vecs[6] = '{2'b00, 2'b11, 4'b1010, 2'b11, 32, 512, 32, 64, 32, 508, 0};
        vecs[7] = '{2'b10, 2'b10, 4'b0100, 2'b10, 32, 512, 31, 62, 32, 512, 0};

        rst = 1'b0;
        idle();
        #12;

        // Reset values, ready pattern 1,1,1,0 and 20 idle cycles.
        do_reset();
        check_all("rst", 32, 512, 32, 64, 32, 512, 0);
        check("rst_ready", int'(ready), 1);
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("ready_c%0d", k), int'(ready), (k % 4 == 3) ? 0 : 1);
        end
        repeat (13) step();
        check_all("idle20", 32, 512, 32, 64, 32, 512, 0);

        // Single-cycle vectors, each from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive(vecs[i].hdr, vecs[i].data, vecs[i].typ, vecs[i].val);
            step();
            idle();
            check_all($sformatf("v%0d", i), vecs[i].ph, vecs[i].pd, vecs[i].nph,
                      vecs[i].npd, vecs[i].cplh, vecs[i].cpld, vecs[i].err);
        end

        // Return latency: consume at N, visible N+1, returned at N+9.
        do_reset();
        drive(2'b01, 2'b01, 4'b0000, 2'b01);
        step();
        idle();
        check("ret_n1_ph", int'(ph), 31);
        check("ret_n1_pd", int'(pd), 510);
        repeat (7) step();
        check("ret_n8_ph", int'(ph), 31);
        check("ret_n8_pd", int'(pd), 510);
        step();
`ifdef PCIE_TX_CREDIT_RETURN_EN
        check("ret_n9_ph", int'(ph), 32);
        check("ret_n9_pd", int'(pd), 512);
`else
        check("ret_n9_ph", int'(ph), 31);
        check("ret_n9_pd", int'(pd), 510);
`endif

        // Consume netted against a landing return in the same cycle.
        do_reset();
        drive(2'b01, 2'b00, 4'b0000, 2'b00);
        step();
        idle();
        repeat (7) step();
        check("net_pre_ph", int'(ph), 31);
        drive(2'b11, 2'b00, 4'b0100, 2'b00);
        step();
        idle();
`ifdef PCIE_TX_CREDIT_RETURN_EN
        check("net_ph", int'(ph), 31);
`else
        check("net_ph", int'(ph), 30);
`endif
        check("net_nph", int'(nph), 31);
        check("net_err", int'(err), 0);

        // CPLH drain at 2 per cycle from both segments.
        do_reset();
        drive(2'b11, 2'b00, 4'b1010, 2'b00);
        repeat (16) step();
`ifdef PCIE_TX_CREDIT_RETURN_EN
        check("drain16_cplh", int'(cplh), 16);
        check("drain16_err", int'(err), 0);
        step();
        check("drain17_cplh", int'(cplh), 16);
        check("drain17_err", int'(err), 0);
`else
        check("drain16_cplh", int'(cplh), 0);
        check("drain16_err", int'(err), 0);
        step();
        check("drain17_cplh", int'(cplh), 0);
        check("drain17_err", int'(err), 1);
`endif
        idle();
        step();
        check("drain_idle_cplh_err", int'(err),
`ifdef PCIE_TX_CREDIT_RETURN_EN
              0);
`else
              1);
`endif

        // Reserved type: error sticky until reset, counters untouched.
        do_reset();
        drive(2'b10, 2'b00, 4'b1100, 2'b00);
        step();
        idle();
        check_all("rsvd", 32, 512, 32, 64, 32, 512, 1);
        repeat (5) step();
        check("rsvd_hold_err", int'(err), 1);
        #2 rst = 1'b0;
        #1;
        check("rsvd_clr_err", int'(err), 0);

        // Reset mid-drain restores INIT asynchronously and drops pending returns.
        do_reset();
        drive(2'b11, 2'b11, 4'b0000, 2'b11);
        repeat (5) step();
        check("mid_ph", int'(ph), 22);
        check("mid_pd", int'(pd), 492);
        #3 rst = 1'b0;
        #1;
        idle();
        check("mid_async_ph", int'(ph), 32);
        check("mid_async_pd", int'(pd), 512);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) step();
        check_all("mid_after", 32, 512, 32, 64, 32, 512, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
